// File: rtl/phy_tx_ser_pkg.sv
// Shared PHY constants: the symbol width and the COM comma symbol. phy_rx uses the same values.
// This package also holds the transmit serializer's slot, counter and FSM encodings.
package phy_tx_ser_pkg;

  localparam int unsigned SYM_W   = 8;
  localparam logic [SYM_W-1:0] PHY_COM = 8'hBC;

  localparam int unsigned SLOT_W  = 3;
  localparam logic [SLOT_W-1:0] SLOT_LAST = 3'd7;

  // The sync counter must be able to count up to 15 COM symbols.
  localparam int unsigned CNT_W   = 4;

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef logic [SYM_W-1:0] sym_t;

endpackage

// File: rtl/phy_tx_ser_if.sv
// Byte-in / bit-out bundle of the PHY transmit serializer.
// The master is the upstream byte source. The slave is phy_tx_ser.
interface phy_tx_ser_if;
  import phy_tx_ser_pkg::*;

  sym_t data_in;
  logic valid_in;
  logic ready_out;
  logic data_out;
  logic active_out;
  logic sync_done;

  modport master (
    output data_in, valid_in,
    input  ready_out, data_out, active_out, sync_done
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out, active_out, sync_done
  );

endinterface

// File: rtl/phy_tx_ser.sv
// PHY transmit serializer. It sends SYNC_COM COM symbols after reset, then sends accepted bytes MSB first.
// Each symbol takes 8 clk_8f cycles. A slot with no accepted byte carries a COM symbol.
module phy_tx_ser
  import phy_tx_ser_pkg::*;
#(
  parameter int unsigned SYNC_COM = 4,
  parameter sym_t        COM      = PHY_COM
) (
  input  logic        clk_8f,
  input  logic        reset,
  phy_tx_ser_if.slave bus
);

  logic [SLOT_W-1:0] r_slot;
  logic [CNT_W-1:0]  r_cnt;
  logic [0:0]        r_state;
  logic [SYM_W-2:0]  r_shift;
  logic              r_data_out;
  logic              r_ready_out;
  logic              r_active_out;
  logic              r_sync_done;

  logic w_last_slot;
  logic w_last_sync;
  logic w_accept;

  // r_slot names the slot that the coming edge puts on data_out.
  assign w_last_slot = (r_slot == SLOT_LAST);
  assign w_last_sync = (r_state == ST_SYNC) && (r_cnt == CNT_W'(SYNC_COM - 1));
  assign w_accept    = r_ready_out && bus.valid_in;

  // NOTE: state registers use non-blocking assignments. Every next-state term then reads the values from before the edge.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      r_slot       <= '0;
      r_cnt        <= '0;
      r_state      <= ST_SYNC;
      r_shift      <= COM[SYM_W-2:0];
      r_data_out   <= 1'b0;
      r_ready_out  <= 1'b0;
      r_active_out <= 1'b0;
      r_sync_done  <= 1'b0;
    end else begin
      r_slot      <= r_slot + SLOT_W'(1);
      r_ready_out <= w_last_slot && ((r_state == ST_RUN) || w_last_sync);

      // Slot 0 loads the new symbol. Its MSB goes out on this same edge, so the byte has one-cycle latency.
      if (r_slot == '0) begin
        if (w_accept) begin
          r_data_out   <= bus.data_in[SYM_W-1];
          r_shift      <= bus.data_in[SYM_W-2:0];
          r_active_out <= 1'b1;
        end else begin
          r_data_out   <= COM[SYM_W-1];
          r_shift      <= COM[SYM_W-2:0];
          r_active_out <= 1'b0;
        end
      end else begin
        r_data_out <= r_shift[SYM_W-2];
        r_shift    <= {r_shift[SYM_W-3:0], 1'b0};
      end

      if (w_last_slot && (r_state == ST_SYNC)) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last_sync) begin
          r_state     <= ST_RUN;
          r_sync_done <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.ready_out  = r_ready_out;
  assign bus.active_out = r_active_out;
  assign bus.sync_done  = r_sync_done;

endmodule
